// File: rtl/sat_pkg.sv
// ----------------------------------------------------------------------------
// sat_pkg
//   Shared definitions for the saturating arithmetic blocks.
//   - state_e  : frame FSM states used by sat_mac
//   - BOUND_W  : width used internally to hold saturation bounds
//   - sat_max / sat_min : signed bounds of a two's complement value of a
//                         given width, sign-extended to BOUND_W bits
//   - max_int  : elaboration-time helper for sizing datapaths
// ----------------------------------------------------------------------------
package sat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no beat of the current frame taken yet
    ACC  = 2'd1,  // at least one beat accumulated
    OUT  = 2'd2   // frame result held on the output
  } state_e;

  // Wide enough for any realistic operand/accumulator configuration.
  localparam int unsigned BOUND_W = 128;

  // Largest value representable in 'width' signed bits: 2^(width-1)-1.
  function automatic logic signed [BOUND_W-1:0] sat_max(input int unsigned width);
    logic signed [BOUND_W-1:0] one;
    one = 1;
    return (one <<< (width - 1)) - one;
  endfunction

  // Smallest value representable in 'width' signed bits: -2^(width-1).
  // Bitwise inverse of sat_max gives exactly that in two's complement.
  function automatic logic signed [BOUND_W-1:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// ----------------------------------------------------------------------------
// sat_clamp
//   Combinational signed clamp from IN_W bits down to OUT_W bits.
//   Ports:
//     din_i     in   IN_W   signed value to clamp
//     dout_o    out  OUT_W  clamped value (0x7F..F / 0x80..0 on saturation)
//     sat_pos_o out  1      din_i exceeded the positive bound
//     sat_neg_o out  1      din_i was below the negative bound
// ----------------------------------------------------------------------------
module sat_clamp
  import sat_pkg::*;
#(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    sat_pos_o,
  output logic                    sat_neg_o
);

  localparam logic signed [BOUND_W-1:0] MAX_V = sat_max(OUT_W);
  localparam logic signed [BOUND_W-1:0] MIN_V = sat_min(OUT_W);

  // Sign-extend to the bound width so the comparisons are exact for any
  // IN_W/OUT_W combination.
  logic signed [BOUND_W-1:0] din_ext;
  assign din_ext = {{(BOUND_W-IN_W){din_i[IN_W-1]}}, din_i};

  assign sat_pos_o = (din_ext > MAX_V);
  assign sat_neg_o = (din_ext < MIN_V);

  always_comb begin
    dout_o = din_ext[OUT_W-1:0];
    if (sat_pos_o) begin
      dout_o = MAX_V[OUT_W-1:0];
    end else if (sat_neg_o) begin
      dout_o = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sat_mac.sv
// ----------------------------------------------------------------------------
// sat_mac
//   Saturating multiply-accumulate over a frame of signed (a,b) beats.
//   Each beat adds a*b to the accumulator and clamps the result to ACC_W bits;
//   the frame result is presented the cycle after the last beat transfers.
//   Ports:
//     clk        in   1      clock, rising edge
//     rst_n      in   1      asynchronous active-low reset
//     clr        in   1      synchronous abort back to IDLE
//     in_vld     in   1      input beat valid
//     in_rdy     out  1      input beat ready (low only while a result is held)
//     in_a/in_b  in   W      signed operands
//     in_last    in   1      final beat of frame
//     out_vld    out  1      frame result valid
//     out_rdy    in   1      downstream accepts result
//     out_acc    out  ACC_W  saturated frame accumulation
//     out_sat    out  1      some beat of the frame clamped
//     ovf_sticky out  1      only with SAT_MAC_STICKY_EN: any clamp since
//                            reset/clr, not cleared by frame accept
//   Build option: define SAT_MAC_STICKY_EN to add ovf_sticky.
// ----------------------------------------------------------------------------
module sat_mac
  import sat_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic signed [W-1:0]     in_a,
  input  logic signed [W-1:0]     in_b,
  input  logic                    in_last,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
`ifdef SAT_MAC_STICKY_EN
  ,
  output logic                    ovf_sticky
`endif
);

  localparam int unsigned PROD_W = 2 * W;
  // One extra bit over the wider operand so base+prod can never wrap.
  localparam int unsigned SUM_W  = max_int(ACC_W, PROD_W) + 1;

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    frame_sat_q, frame_sat_d;
  logic                    out_vld_q, out_vld_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic                    out_sat_q, out_sat_d;

  logic                    in_fire;
  logic                    out_fire;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  clamped;
  logic                     sat_pos;
  logic                     sat_neg;
  logic                     beat_sat;

  assign in_fire  = in_vld & in_rdy;
  assign out_fire = out_vld_q & out_rdy;

  // --------------------------------------------------------------------------
  // Datapath: full-precision product, accumulate, clamp.
  // --------------------------------------------------------------------------
  assign prod = PROD_W'(in_a) * PROD_W'(in_b);
  // A new frame starts from zero regardless of what acc_q still holds.
  assign base = (state_q == IDLE) ? '0 : acc_q;
  assign sum  = SUM_W'(base) + SUM_W'(prod);

  sat_clamp #(
    .IN_W  (SUM_W),
    .OUT_W (ACC_W)
  ) u_clamp (
    .din_i     (sum),
    .dout_o    (clamped),
    .sat_pos_o (sat_pos),
    .sat_neg_o (sat_neg)
  );

  assign beat_sat = sat_pos | sat_neg;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (in_fire) begin
          state_d = in_last ? OUT : ACC;
        end
      end
      OUT: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
    end
  end

  // FSM: outputs
  always_comb begin
    in_rdy = (state_q != OUT);
  end

  // --------------------------------------------------------------------------
  // Accumulator and result registers
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d       = acc_q;
    frame_sat_d = frame_sat_q;
    out_vld_d   = out_vld_q;
    out_acc_d   = out_acc_q;
    out_sat_d   = out_sat_q;
    if (clr) begin
      // out_acc/out_sat are left alone; they are meaningless while out_vld=0.
      acc_d       = '0;
      frame_sat_d = 1'b0;
      out_vld_d   = 1'b0;
    end else begin
      // in_fire and out_fire are exclusive: in_rdy is low while a result is held.
      if (in_fire) begin
        acc_d       = clamped;
        frame_sat_d = ((state_q == IDLE) ? 1'b0 : frame_sat_q) | beat_sat;
        if (in_last) begin
          out_vld_d = 1'b1;
          out_acc_d = clamped;
          out_sat_d = frame_sat_d;
        end
      end
      if (out_fire) begin
        out_vld_d   = 1'b0;
        frame_sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      frame_sat_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      frame_sat_q <= frame_sat_d;
      out_vld_q   <= out_vld_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_acc = out_acc_q;
  assign out_sat = out_sat_q;

`ifdef SAT_MAC_STICKY_EN
  // --------------------------------------------------------------------------
  // Sticky overflow: survives frame accept, cleared only by reset or clr.
  // --------------------------------------------------------------------------
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | (in_fire & beat_sat);
    if (clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_sat_mac.sv
// ----------------------------------------------------------------------------
// tb_sat_mac
//   Drives directed and random frames into sat_mac (W=16, ACC_W=16) and
//   compares every result against an integer reference of the frame rules.
// ----------------------------------------------------------------------------
module tb_sat_mac;

  localparam longint POS_LIM = 32767;
  localparam longint NEG_LIM = -32768;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               in_vld;
  logic               in_rdy;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_last;
  logic               out_vld;
  logic               out_rdy;
  logic signed [15:0] out_acc;
  logic               out_sat;
`ifdef SAT_MAC_STICKY_EN
  logic               ovf_sticky;
`endif

  int total = 0;
  int bad   = 0;

  longint qa[$];
  longint qb[$];

  sat_mac #(
    .W     (16),
    .ACC_W (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_last (in_last),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_acc (out_acc),
    .out_sat (out_sat)
`ifdef SAT_MAC_STICKY_EN
    ,
    .ovf_sticky (ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint rnd_op();
    longint v;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 16)) - 8;
      1: v = ($urandom_range(0, 1) == 1) ? POS_LIM : NEG_LIM;
      2: v = longint'($signed(16'($urandom)));
      default: v = longint'($urandom_range(0, 511)) - 256;
    endcase
    return v;
  endfunction

  // Offer one beat starting at a falling edge; return at the falling edge
  // after it transferred.
  task automatic send_beat(input string tag, input longint a, input longint b, input bit last);
    int n;
    in_vld  = 1'b1;
    in_a    = 16'(a);
    in_b    = 16'(b);
    in_last = last;
    n = 0;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, ":rdy_timeout"}, 0, 1);
    @(negedge clk);
    in_vld  = 1'b0;
    in_last = 1'b0;
    in_a    = 16'($urandom);
    in_b    = 16'($urandom);
  endtask

  // Send the frame held in qa/qb, check the result against the reference,
  // hold it for 'hold' cycles with junk beats offered, then accept it.
  task automatic run_frame(input string tag, input int hold, input bit gaps);
    longint acc;
    longint s;
    bit     sat;
    acc = 0;
    sat = 0;
    foreach (qa[i]) begin
      s = acc + qa[i] * qb[i];
      if (s > POS_LIM) begin
        acc = POS_LIM;
        sat = 1;
      end else if (s < NEG_LIM) begin
        acc = NEG_LIM;
        sat = 1;
      end else begin
        acc = s;
      end
    end
    foreach (qa[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      send_beat(tag, qa[i], qb[i], i == qa.size() - 1);
    end
    chk({tag, ":vld"}, longint'(out_vld), 1);
    chk({tag, ":acc"}, longint'(out_acc) & 64'hFFFF, acc & 64'hFFFF);
    chk({tag, ":sat"}, longint'(out_sat), longint'(sat));
    for (int h = 0; h < hold; h++) begin
      in_vld  = 1'b1;
      in_last = 1'b1;
      in_a    = 16'($urandom);
      in_b    = 16'($urandom);
      @(negedge clk);
      chk({tag, ":hold_vld"}, longint'(out_vld), 1);
      chk({tag, ":hold_acc"}, longint'(out_acc) & 64'hFFFF, acc & 64'hFFFF);
      chk({tag, ":hold_sat"}, longint'(out_sat), longint'(sat));
      chk({tag, ":hold_rdy"}, longint'(in_rdy), 0);
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    chk({tag, ":acc_vld"}, longint'(out_vld), 0);
    chk({tag, ":acc_rdy"}, longint'(in_rdy), 1);
    $display("frame %s beats=%0d exp=0x%04h sat=%0d got=0x%04h", tag, qa.size(),
             acc & 64'hFFFF, sat, out_acc);
  endtask

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    in_vld  = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_last = 1'b0;
    out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset:vld", longint'(out_vld), 0);
    chk("reset:acc", longint'(out_acc), 0);
    chk("reset:sat", longint'(out_sat), 0);
    chk("reset:rdy", longint'(in_rdy), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset:rdy", longint'(in_rdy), 1);

    // 1: single beat
    qa = '{3};       qb = '{4};       run_frame("t1_single", 0, 0);
    // 2: positive saturation
    qa = '{32767, 1}; qb = '{2, 1};   run_frame("t2_possat", 0, 0);
`ifdef SAT_MAC_STICKY_EN
    chk("sticky_after_accept", longint'(ovf_sticky), 1);
`endif
    // 3: recovery from clamped value
    qa = '{16384, -1}; qb = '{2, 1};  run_frame("t3_recover", 0, 0);
    // 4: negative saturation, then most-negative squared
    qa = '{-32768, -1}; qb = '{1, 1}; run_frame("t4_negsat", 0, 0);
    qa = '{-32768};  qb = '{-32768};  run_frame("t4_minsq", 0, 0);
    // 5: backpressure, then next frame
    qa = '{3};       qb = '{4};       run_frame("t5_hold", 5, 0);
    qa = '{1};       qb = '{1};       run_frame("t5_next", 0, 0);

    // 6a: abort mid-frame with clr; the beat offered alongside clr is dropped
    send_beat("t6_clr", 2, 5, 0);
    send_beat("t6_clr", 0, 0, 0);
    clr     = 1'b1;
    in_vld  = 1'b1;
    in_a    = 16'sd7;
    in_b    = 16'sd7;
    in_last = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    in_vld  = 1'b0;
    in_last = 1'b0;
    chk("t6_clr:vld", longint'(out_vld), 0);
    chk("t6_clr:rdy", longint'(in_rdy), 1);
`ifdef SAT_MAC_STICKY_EN
    chk("t6_clr:sticky", longint'(ovf_sticky), 0);
`endif
    qa = '{1}; qb = '{1}; run_frame("t6_after_clr", 0, 0);

    // 6b: asynchronous reset mid-frame
    send_beat("t6_rst", 2, 5, 0);
    send_beat("t6_rst", 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst:vld", longint'(out_vld), 0);
    chk("t6_rst:acc", longint'(out_acc), 0);
    chk("t6_rst:sat", longint'(out_sat), 0);
    chk("t6_rst:rdy", longint'(in_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = '{1}; qb = '{1}; run_frame("t6_after_rst", 0, 0);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      qa.delete();
      qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(rnd_op());
        qb.push_back(rnd_op());
      end
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 2), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
